sme_feeder: RTL and testbench
=============================

// Module: sme_feeder
// PURPOSE
//  Upstream stage of the string-matching engine (SME). Accepts a valid/ready byte stream of
//  string and pattern items, buffers them, and replays each pattern to the SME on
//  chardata/isstring/ispattern with the exact burst timing the SME requires. Returns the
//  SME verdict tagged with a pattern sequence number.
// PARAMETERS
//  STR_MAX  32  max string bytes buffered; extra bytes dropped
//  PAT_MAX  8   max pattern bytes buffered, incl. ^ $ * .; extra bytes dropped
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  asynchronous, active-high reset
//  s_valid      in   1  input byte valid
//  s_ready      out  1  feeder accepts byte this cycle
//  s_data       in   8  input byte (ASCII)
//  s_kind       in   1  0=string item, 1=pattern item; sampled on first beat of item only
//  s_last       in   1  last byte of current item
//  chardata     out  8  byte to SME
//  isstring     out  1  SME string burst strobe
//  ispattern    out  1  SME pattern burst strobe
//  sme_valid    in   1  SME result strobe
//  sme_match    in   1  SME match flag
//  sme_index    in   5  SME match index
//  r_valid      out  1  result pulse
//  r_match      out  1  match flag of result
//  r_index      out  5  match index (0 when r_match=0)
//  r_pat_id     out  8  pattern number since last string, first pattern = 0
//  err_ovf      out  1  1-cycle pulse: byte dropped due to STR_MAX/PAT_MAX overflow
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, buffers/lengths cleared, str_new=0, pat_id=0.
//    Reset mid-burst aborts immediately; SME is reset by the same signal.
//  - All outputs registered. Handshake: byte transferred when s_valid && s_ready.
//  - s_ready=1 only in IDLE and LOAD; 0 in SEND_S, SEND_P, WAIT.
//  - FSM: IDLE -beat-> LOAD (latch kind, store byte); LOAD stores bytes until s_last beat
//    (single-beat item with s_last goes directly to end-of-item handling).
//    End of string item: str_len latched, str_new=1, pat_id=0, -> IDLE; no SME activity.
//    End of pattern item: -> SEND_S if str_new else SEND_P.
//  - SEND_S: isstring=1, chardata=str[k], k=0..str_len-1, one byte/cycle; cycle after last
//    string byte MUST be SEND_P's first cycle (no gap: SME treats any gap as end of pattern).
//    str_new cleared on exit.
//  - SEND_P: ispattern=1, chardata=pat[k], k=0..pat_len-1; then strobes drop -> WAIT.
//  - Idle strobes: isstring=ispattern=0, chardata=0.
//  - Latency: first strobe cycle = cycle after s_last beat accepted. Total SME feed =
//    str_len(if str_new)+pat_len cycles.
//  - WAIT: on sme_valid: next cycle r_valid=1, r_match=sme_match,
//    r_index=sme_match?sme_index:0, r_pat_id=pat_id; pat_id+=1 (8-bit wrap 255->0); -> IDLE.
//  - sme_valid outside WAIT ignored (no r_valid).
//  - Overflow: bytes beyond STR_MAX/PAT_MAX still accepted (s_ready=1), not stored, err_ovf
//    pulses per dropped byte; item truncated to max length. s_last on a dropped byte still
//    ends the item.
//  - Pattern item with no prior string: sent as pattern-only burst (SME keeps old/blank string).
//  - Consecutive strings without pattern: last one wins.
//  - Lengths counted with 6-bit (string) and 4-bit (pattern) counters; no wrap beyond max.
// TESTING
//  1 reset, string "ABCD"(last on D), pattern "BC" -> isstring 4 cyc A,B,C,D then ispattern
//    2 cyc B,C with zero gap; SME valid match=1 idx=1 -> r_valid, r_match=1, r_index=1, r_pat_id=0
//  2 after 1, pattern "X*" then "^AB" -> pattern-only bursts, no isstring; r_pat_id 1 then 2
//  3 40-byte string -> 32 stored, err_ovf pulses 8 times, isstring burst exactly 32 cycles
//  4 10-byte pattern -> 8 bytes sent, 2 err_ovf pulses; s_ready=0 from SEND start until r_valid
//  5 sme_valid pulse in IDLE -> no r_valid; sme_valid with match=0 idx=7 in WAIT -> r_index=0
//  6 assert reset during SEND_S byte 2 -> next cycle all strobes 0, s_ready=1, pat_id=0

Source files
------------

// File: rtl/sme_feeder.sv
// Front end of the string-matching engine: buffers string/pattern items from a valid/ready
// byte stream and replays them to the SME as gap-free isstring/ispattern bursts.
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_kind,
  input  logic       s_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       r_valid,
  output logic       r_match,
  output logic [4:0] r_index,
  output logic [7:0] r_pat_id,
  output logic       err_ovf,
  output logic [2:0] dbg_state
);

  // Handshake: a byte moves on a rising edge where s_valid && s_ready are both high;
  // s_ready is registered and only high in IDLE/LOAD, so the source may hold s_valid freely.

  localparam int SW = $clog2(STR_MAX);
  localparam int PW = $clog2(PAT_MAX);
  localparam logic [5:0] STR_MAX_W = 6'(STR_MAX);
  localparam logic [5:0] PAT_MAX_W = 6'(PAT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SEND_S = 3'd2,
    ST_SEND_P = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        kind_q, kind_d;
  logic [5:0]  wr_cnt_q, wr_cnt_d;
  logic [7:0]  str_q [STR_MAX];
  logic [7:0]  str_d [STR_MAX];
  logic [7:0]  pat_q [PAT_MAX];
  logic [7:0]  pat_d [PAT_MAX];
  logic [5:0]  str_len_q, str_len_d;
  logic [3:0]  pat_len_q, pat_len_d;
  logic        str_new_q, str_new_d;
  logic [7:0]  pat_id_q, pat_id_d;
  logic [5:0]  k_q, k_d;
  logic        s_ready_q, s_ready_d;
  logic [7:0]  chardata_q, chardata_d;
  logic        isstring_q, isstring_d;
  logic        ispattern_q, ispattern_d;
  logic        r_valid_q, r_valid_d;
  logic        r_match_q, r_match_d;
  logic [4:0]  r_index_q, r_index_d;
  logic [7:0]  r_pat_id_q, r_pat_id_d;
  logic        err_ovf_q, err_ovf_d;

  logic        beat;
  logic        cur_kind;
  logic [5:0]  base;
  logic        room;
  logic [5:0]  new_len;
  logic [5:0]  kn;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    wr_cnt_d    = wr_cnt_q;
    str_d       = str_q;
    pat_d       = pat_q;
    str_len_d   = str_len_q;
    pat_len_d   = pat_len_q;
    str_new_d   = str_new_q;
    pat_id_d    = pat_id_q;
    k_d         = k_q;
    chardata_d  = 8'd0;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    r_valid_d   = 1'b0;
    r_match_d   = r_match_q;
    r_index_d   = r_index_q;
    r_pat_id_d  = r_pat_id_q;
    err_ovf_d   = 1'b0;

    beat     = s_valid && s_ready_q;
    // Kind is only taken from the first beat; later beats reuse the latched value.
    cur_kind = (state_q == ST_IDLE) ? s_kind : kind_q;
    base     = (state_q == ST_IDLE) ? 6'd0 : wr_cnt_q;
    room     = cur_kind ? (base < PAT_MAX_W) : (base < STR_MAX_W);
    new_len  = base + {5'd0, room};
    kn       = k_q + 6'd1;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (beat) begin
          kind_d   = cur_kind;
          wr_cnt_d = new_len;
          if (room) begin
            if (cur_kind) pat_d[base[PW-1:0]] = s_data;
            else          str_d[base[SW-1:0]] = s_data;
          end else begin
            err_ovf_d = 1'b1;
          end
          if (s_last) begin
            if (!cur_kind) begin
              str_len_d = new_len;
              str_new_d = 1'b1;
              pat_id_d  = 8'd0;
              state_d   = ST_IDLE;
            end else begin
              pat_len_d = new_len[3:0];
              k_d       = 6'd0;
              if (str_new_q) begin
                state_d    = ST_SEND_S;
                isstring_d = 1'b1;
                chardata_d = str_q[0];
              end else begin
                // pat_d so a single-beat pattern sees the byte stored this cycle
                state_d     = ST_SEND_P;
                ispattern_d = 1'b1;
                chardata_d  = pat_d[0];
              end
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_SEND_S: begin
        if (k_q == str_len_q - 6'd1) begin
          // Pattern follows on the very next cycle: the SME reads a gap as end of pattern.
          state_d     = ST_SEND_P;
          str_new_d   = 1'b0;
          k_d         = 6'd0;
          ispattern_d = 1'b1;
          chardata_d  = pat_q[0];
        end else begin
          k_d        = kn;
          isstring_d = 1'b1;
          chardata_d = str_q[kn[SW-1:0]];
        end
      end
      ST_SEND_P: begin
        if (k_q == {2'b00, pat_len_q} - 6'd1) begin
          state_d = ST_WAIT;
        end else begin
          k_d         = kn;
          ispattern_d = 1'b1;
          chardata_d  = pat_q[kn[PW-1:0]];
        end
      end
      ST_WAIT: begin
        if (sme_valid) begin
          r_valid_d  = 1'b1;
          r_match_d  = sme_match;
          r_index_d  = sme_match ? sme_index : 5'd0;
          r_pat_id_d = pat_id_q;
          pat_id_d   = pat_id_q + 8'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      kind_q      <= 1'b0;
      wr_cnt_q    <= 6'd0;
      for (int i = 0; i < STR_MAX; i++) str_q[i] <= 8'd0;
      for (int i = 0; i < PAT_MAX; i++) pat_q[i] <= 8'd0;
      str_len_q   <= 6'd0;
      pat_len_q   <= 4'd0;
      str_new_q   <= 1'b0;
      pat_id_q    <= 8'd0;
      k_q         <= 6'd0;
      s_ready_q   <= 1'b0;
      chardata_q  <= 8'd0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      r_valid_q   <= 1'b0;
      r_match_q   <= 1'b0;
      r_index_q   <= 5'd0;
      r_pat_id_q  <= 8'd0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      wr_cnt_q    <= wr_cnt_d;
      str_q       <= str_d;
      pat_q       <= pat_d;
      str_len_q   <= str_len_d;
      pat_len_q   <= pat_len_d;
      str_new_q   <= str_new_d;
      pat_id_q    <= pat_id_d;
      k_q         <= k_d;
      s_ready_q   <= s_ready_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      r_valid_q   <= r_valid_d;
      r_match_q   <= r_match_d;
      r_index_q   <= r_index_d;
      r_pat_id_q  <= r_pat_id_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign r_valid   = r_valid_q;
  assign r_match   = r_match_q;
  assign r_index   = r_index_q;
  assign r_pat_id  = r_pat_id_q;
  assign err_ovf   = err_ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: a pattern table applied after a reference string, plus
// hand-written sequences for overflow, stray SME strobes, reset mid-burst and pat_id wrap.
module tb_sme_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'd0;
  logic       s_kind = 1'b0;
  logic       s_last = 1'b0;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid = 1'b0;
  logic       sme_match = 1'b0;
  logic [4:0] sme_index = 5'd0;
  logic       r_valid;
  logic       r_match;
  logic [4:0] r_index;
  logic [7:0] r_pat_id;
  logic       err_ovf;
  logic [2:0] dbg_state;

  sme_feeder dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_kind(s_kind), .s_last(s_last),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
    .r_valid(r_valid), .r_match(r_match), .r_index(r_index), .r_pat_id(r_pat_id),
    .err_ovf(err_ovf), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  exp_q[$];
  logic [9:0]  got_q[$];
  logic [13:0] res_q[$];
  int burst_cnt = 0;
  int ovf_cnt   = 0;
  int rdy_viol  = 0;
  logic prev_act = 1'b0;

  logic [7:0] item_b [40];
  logic [7:0] cur_str [32];
  int cur_str_len = 0;

  // monitor: records every strobe cycle, burst ends, overflow pulses and results
  always @(negedge clk) begin
    if (reset) begin
      prev_act = 1'b0;
    end else begin
      if (isstring || ispattern) got_q.push_back({isstring, ispattern, chardata});
      if (prev_act && !(isstring || ispattern)) burst_cnt++;
      if ((isstring || ispattern) && s_ready) rdy_viol++;
      if (err_ovf) ovf_cnt++;
      if (r_valid) res_q.push_back({r_match, r_index, r_pat_id});
      prev_act = isstring || ispattern;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] d, input logic k, input logic last);
    int guard;
    s_valid = 1'b1;
    s_data  = d;
    s_kind  = k;
    s_last  = last;
    guard = 0;
    while (!s_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!s_ready) check("s_ready_wait", {31'd0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_kind  = 1'b0;
  endtask

  // later beats drive the opposite kind: only the first beat may decide it
  task automatic send_item(input int len, input logic k);
    for (int i = 0; i < len; i++) send_byte(item_b[i], (i == 0) ? k : ~k, i == len - 1);
  endtask

  task automatic load_txt(input logic [79:0] t, input int len);
    for (int i = 0; i < len; i++) item_b[i] = t[8*(len-1-i) +: 8];
  endtask

  task automatic send_string(input string name, input int len);
    int o0, b0, exp_ovf;
    o0 = ovf_cnt;
    b0 = burst_cnt;
    send_item(len, 1'b0);
    check({name, "/no_strobe"}, {30'd0, isstring, ispattern}, 32'd0);
    check({name, "/s_ready"}, {31'd0, s_ready}, 32'd1);
    tick();
    exp_ovf = (len > 32) ? len - 32 : 0;
    check({name, "/ovf_count"}, ovf_cnt - o0, exp_ovf);
    check({name, "/no_burst"}, burst_cnt - b0, 32'd0);
    cur_str_len = (len > 32) ? 32 : len;
    for (int i = 0; i < cur_str_len; i++) cur_str[i] = item_b[i];
  endtask

  task automatic run_pattern(input string name, input int len, input logic m,
                             input logic [4:0] idx, input logic exp_str,
                             input logic [4:0] exp_idx, input logic [7:0] exp_id);
    int b0, o0, guard, sent, exp_ovf;
    logic [9:0] e, g;
    logic [13:0] r;
    exp_q.delete();
    got_q.delete();
    if (exp_str) for (int i = 0; i < cur_str_len; i++) exp_q.push_back({2'b10, cur_str[i]});
    sent = (len > 8) ? 8 : len;
    for (int i = 0; i < sent; i++) exp_q.push_back({2'b01, item_b[i]});
    b0 = burst_cnt;
    o0 = ovf_cnt;
    send_item(len, 1'b1);
    check({name, "/first_strobe"}, {30'd0, isstring, ispattern}, exp_str ? 32'd2 : 32'd1);
    guard = 0;
    while (burst_cnt == b0 && guard < 100) begin
      tick();
      guard++;
    end
    check({name, "/one_burst"}, burst_cnt - b0, 32'd1);
    check({name, "/burst_len"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'h3ff;
      check({name, "/burst_byte"}, {22'd0, g}, {22'd0, e});
    end
    exp_ovf = (len > 8) ? len - 8 : 0;
    check({name, "/ovf_count"}, ovf_cnt - o0, exp_ovf);
    check({name, "/wait_state"}, {29'd0, dbg_state}, 32'd4);
    check({name, "/wait_not_ready"}, {31'd0, s_ready}, 32'd0);
    check({name, "/ready_in_burst"}, rdy_viol, 32'd0);
    sme_valid = 1'b1;
    sme_match = m;
    sme_index = idx;
    tick();
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = 5'd0;
    guard = 0;
    while (res_q.size() == 0 && guard < 20) begin
      tick();
      guard++;
    end
    check({name, "/r_valid_count"}, res_q.size(), 32'd1);
    r = (res_q.size() > 0) ? res_q.pop_front() : 14'h3fff;
    check({name, "/r_match"}, {31'd0, r[13]}, {31'd0, m});
    check({name, "/r_index"}, {27'd0, r[12:8]}, {27'd0, exp_idx});
    check({name, "/r_pat_id"}, {24'd0, r[7:0]}, {24'd0, exp_id});
    check({name, "/ready_after"}, {31'd0, s_ready}, 32'd1);
    tick();
    check({name, "/r_valid_pulse"}, {31'd0, r_valid}, 32'd0);
    res_q.delete();
  endtask

  typedef struct {
    logic [79:0] txt;
    int          len;
    logic        match;
    logic [4:0]  idx;
    logic        exp_str;
    logic [4:0]  exp_idx;
    logic [7:0]  exp_id;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{txt: "BC",         len: 2,  match: 1'b1, idx: 5'd1,  exp_str: 1'b1, exp_idx: 5'd1,  exp_id: 8'd0};
    vecs[1] = '{txt: "X*",         len: 2,  match: 1'b0, idx: 5'd3,  exp_str: 1'b0, exp_idx: 5'd0,  exp_id: 8'd1};
    vecs[2] = '{txt: "^AB",        len: 3,  match: 1'b1, idx: 5'd2,  exp_str: 1'b0, exp_idx: 5'd2,  exp_id: 8'd2};
    vecs[3] = '{txt: "ABCDEFGHIJ", len: 10, match: 1'b1, idx: 5'd31, exp_str: 1'b0, exp_idx: 5'd31, exp_id: 8'd3};
    vecs[4] = '{txt: "$",          len: 1,  match: 1'b0, idx: 5'd7,  exp_str: 1'b0, exp_idx: 5'd0,  exp_id: 8'd4};

    // reset state
    tick();
    tick();
    check("reset/s_ready", {31'd0, s_ready}, 32'd0);
    check("reset/strobes", {21'd0, isstring, ispattern, chardata}, 32'd0);
    check("reset/results", {16'd0, r_valid, r_match, r_index, r_pat_id}, 32'd0);
    check("reset/err_ovf", {31'd0, err_ovf}, 32'd0);
    check("reset/state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_reset/s_ready", {31'd0, s_ready}, 32'd1);

    // reference string, then the pattern table
    load_txt("ABCD", 4);
    send_string("str_abcd", 4);
    for (int v = 0; v < 5; v++) begin
      load_txt(vecs[v].txt, vecs[v].len);
      run_pattern($sformatf("vec%0d", v), vecs[v].len, vecs[v].match, vecs[v].idx,
                  vecs[v].exp_str, vecs[v].exp_idx, vecs[v].exp_id);
    end

    // sme_valid outside WAIT is ignored
    sme_valid = 1'b1;
    sme_match = 1'b1;
    sme_index = 5'd9;
    tick();
    sme_valid = 1'b0;
    tick();
    tick();
    check("idle_sme/no_result", res_q.size(), 32'd0);
    check("idle_sme/r_valid", {31'd0, r_valid}, 32'd0);
    res_q.delete();

    // consecutive strings: the last one wins
    load_txt("QQQ", 3);
    send_string("str_qqq", 3);
    load_txt("HI", 2);
    send_string("str_hi", 2);
    load_txt("H.", 2);
    run_pattern("last_str_wins", 2, 1'b1, 5'd0, 1'b1, 5'd0, 8'd0);

    // string overflow: 40 bytes offered, 32 kept
    for (int i = 0; i < 40; i++) item_b[i] = 8'h30 + 8'(i);
    send_string("str_40", 40);
    load_txt("Z", 1);
    run_pattern("after_str_40", 1, 1'b0, 5'd4, 1'b1, 5'd0, 8'd0);

    // reset during the second byte of a string burst
    load_txt("ABCDEF", 6);
    send_string("str_abcdef", 6);
    load_txt("F", 1);
    send_item(1, 1'b1);
    check("rst_mid/byte1", {23'd0, isstring, chardata}, {23'd0, 1'b1, 8'h41});
    tick();
    check("rst_mid/byte2", {23'd0, isstring, chardata}, {23'd0, 1'b1, 8'h42});
    reset = 1'b1;
    #1;
    check("rst_mid/strobes", {21'd0, isstring, ispattern, chardata}, 32'd0);
    check("rst_mid/state", {29'd0, dbg_state}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_mid/s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_mid/strobes_after", {30'd0, isstring, ispattern}, 32'd0);
    got_q.delete();
    res_q.delete();
    cur_str_len = 0;
    load_txt("F", 1);
    run_pattern("after_rst", 1, 1'b1, 5'd5, 1'b0, 5'd5, 8'd0);

    // pat_id keeps counting and wraps 255 -> 0
    load_txt("a", 1);
    for (int n = 1; n <= 256; n++)
      run_pattern($sformatf("wrap%0d", n), 1, 1'b0, 5'd1, 1'b0, 5'd0, 8'(n));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
